fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with a 64x16 program memory, a 16-bit
//               PC and a registered IF/ID output (stall / branch / load aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    input  logic        imemWe,
    input  logic [5:0]  imemAddr,
    input  logic [15:0] imemData,
    output logic [15:0] instruction,
    output logic [15:0] pcPlus1,
    output logic        valid,
    output logic [15:0] pc
);

    localparam int          MEM_DEPTH  = 64;
    localparam logic [0:0]  STATE_IDLE = 1'b0;
    localparam logic [0:0]  STATE_RUN  = 1'b1;
    localparam logic [15:0] C_NOP      = 16'h0000;

    logic [0:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus1_q, pc_plus1_d;
    logic        valid_q, valid_d;
    logic [15:0] mem_q [MEM_DEPTH];
    logic [15:0] w_mem_rdata;
    logic [15:0] w_pc_inc;

    // Program memory is deliberately left out of reset so a loaded program survives it.
    always_ff @(posedge clk) begin
        if (imemWe) begin
            mem_q[imemAddr] <= imemData;
        end
    end

    assign w_mem_rdata = mem_q[pc_q[5:0]];
    assign w_pc_inc    = pc_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        case (state_q)
            STATE_IDLE: begin
                instr_d = C_NOP;
                valid_d = 1'b0;
                if (start && !imemWe) begin
                    state_d = STATE_RUN;
                end
            end
            STATE_RUN: begin
                // Priority: program load, then redirect, then stall, then fetch.
                if (imemWe) begin
                    instr_d = C_NOP;
                    valid_d = 1'b0;
                end else if (branchTaken) begin
                    pc_d    = branchTarget;
                    instr_d = C_NOP;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d    = w_mem_rdata;
                    pc_plus1_d = w_pc_inc;
                    pc_d       = w_pc_inc;
                    valid_d    = 1'b1;
                end
            end
            default: begin
                state_d = STATE_IDLE;
                instr_d = C_NOP;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STATE_IDLE;
            pc_q       <= 16'h0000;
            instr_q    <= C_NOP;
            pc_plus1_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign pcPlus1     = pc_plus1_q;
    assign valid       = valid_q;
    assign pc          = pc_q;

endmodule

`default_nettype wire
